idli_sqi_ctrl_m: RTL
====================

// Module: idli_sqi_ctrl_m
//
// PURPOSE
//  Sequences the nibble-wide SQI memory: fetch stream, load/store redirects and the 4-GCK sync counter.
//  Issues READ/WRITE command, 24b address and dummy phases, then streams 16b words.
//  Provides ctr/enc/enc_vld to idli_decode_m and accepts serial redirect addresses from execute.
//
// PARAMETERS
//  RST_ADDR    16'h0000  word address of the first fetch after reset
//  DUMMY_CYC   2         read dummy cycles (GCK) between address and data
//
// PORTS
//  i_de_gck       in   1       core clock; the SQI clock is GCK gated by ~o_sq_cs_n
//  i_de_rst_n     in   1       reset: asynchronous, active-low
//  o_sq_cs_n      out  1       SQI chip select, active-low
//  o_sq_sio       out  4       SQI output nibble
//  o_sq_sio_oe    out  1       SQI output enable; 0 means tri-state and sample i_sq_sio
//  i_sq_sio       in   4       SQI input nibble
//  i_sq_redir     in   1       redirect request, sampled only in DATA with ctr==3
//  i_sq_redir_wr  in   1       redirect is a write (qualifies i_sq_redir)
//  i_sq_addr      in   4       serial redirect word address, LSB nibble first, ctr 0..3
//  i_sq_wdata     in   4       write data nibble, driven during write DATA
//  o_de_ctr       out  ctr_t   sync counter (2b)
//  o_de_enc       out  data_t  assembled 16b read word (4 nibbles, nibble 0 first on bus)
//  o_de_enc_vld   out  1       o_de_enc complete (read DATA, ctr==3)
//
// BEHAVIOUR
//  Reset values: cs_n=1, sio=0, sio_oe=0, ctr=0, enc_vld=0, state=GAP, pending op=READ at RST_ADDR.
//  Reset asserted mid-transaction aborts it asynchronously: cs_n=1 and sio_oe=0 immediately.
//  State machine: GAP -> CMD(2) -> ADDR(6) -> [DUMMY(DUMMY_CYC), read only] -> DATA.
//  GAP: exactly 1 cycle with cs_n=1. Every other state has cs_n=0.
//  CMD: drives the command nibbles high nibble first: READ 0x0,0x3; WRITE 0x0,0x2. sio_oe=1.
//  ADDR: byte address {7'b0, waddr[15:0], 1'b0}, 6 nibbles, MSB first. sio_oe=1.
//  DUMMY: sio_oe=0, sio=0.
//  DATA: ctr increments every cycle and wraps 3->0. ctr is held at 0 in every other state.
//  Read DATA: sio_oe=0; nibble ctr of i_sq_sio goes to o_de_enc[ctr], same cycle (combinational path for nibble 3).
//  Read DATA: enc_vld=1 iff ctr==3. The memory streams sequential words with no gap.
//  Write DATA: sio_oe=1, o_sq_sio=i_sq_wdata. enc_vld=0.
//  Redirect address: i_sq_addr is shifted into addr_q every DATA cycle; the last 4 nibbles form waddr.
//  Redirect: i_sq_redir with ctr==3 ends the current transaction after that nibble.
//  The next cycle is GAP. The pending op (rd/wr) and waddr are taken from i_sq_redir_wr and addr_q plus the nibble of that cycle.
//  Redirect in any other state, or with ctr!=3, is ignored and flagged by an assertion.
//  Write DATA with no redirect continues sequential writes. Execute issues the redirect back to PC.
//  Latency from redirect at ctr==3 to the first data nibble: read 1+2+6+DUMMY_CYC = 11 cycles; write 9 cycles.
//  Address wrap: sequential streaming past 0xFFFF continues in memory (not re-issued). Software must not rely on it.
//
// CONFIGURATION
//  IDLI_SQI_QUAD_INIT_EN defined: reset enters INIT before the first GAP.
//  INIT: cs_n=0, SPI mode on sio[0] only (sio_oe=1, sio[3:1]=0), sends EQIO 0x38 MSB first over 8 cycles, then GAP.
//  IDLI_SQI_QUAD_INIT_EN undefined: INIT is absent; the memory is already in SQI mode; first GAP at reset release.
//
// STRUCTURE
//  idli_pkg additions:
//   sqi_state_t enum {INIT, GAP, CMD, ADDR, DUMMY, DATA}
//   sqi_op_t {SQI_OP_RD, SQI_OP_WR}
//   localparams SQI_CMD_RD=8'h03, SQI_CMD_WR=8'h02, SQI_CMD_EQIO=8'h38
//  Sub-module idli_sqi_shift_m: 24b load/shift-out register used for the command and address nibbles.
//  FSM, phase counter (max 8) and ctr stay in the top level.
//
// TESTING
//  Reset release, RST_ADDR=0:
//   -> cs_n 1 for 1 cycle, then sio 0,3, then 0,0,0,0,0,0, then 2 cycles oe=0.
//   -> memory word 0xBEEF (nibbles F,E,E,B) gives enc=0xBEEF and enc_vld on cycle 14.
//  Stream 3 words:
//   -> ctr 0,1,2,3 repeating; enc_vld every 4th cycle; no CS gap between words.
//  Read redirect, addr 0x1234 serial 4,3,2,1, redir at ctr==3:
//   -> GAP, CMD 0,3, ADDR 0,0,2,4,6,8, data after 2 dummy cycles.
//  Write redirect, addr 0x0010, wdata 0xA5C3:
//   -> CMD 0,2, ADDR 0,0,0,0,2,0; sio=3,C,5,A with oe=1; enc_vld stays 0.
//  redir at ctr==1 or during ADDR:
//   -> ignored, stream unchanged, assertion fires.
//  Async reset asserted in write DATA:
//   -> cs_n=1, oe=0 same cycle.
//  IDLI_SQI_QUAD_INIT_EN defined:
//   -> 0x38 bit-serial on sio[0] (0,0,1,1,1,0,0,0) before the first GAP.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared idli types and constants; this slice carries the SQI memory controller additions.
package idli_pkg;

  localparam int unsigned NIB_W        = 4;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned CTR_W        = 2;
  localparam int unsigned SQI_SR_W     = 24;
  localparam int unsigned SQI_PHASE_W  = 4;
  localparam int unsigned SQI_CMD_LEN  = 2;
  localparam int unsigned SQI_ADDR_LEN = 6;
  localparam int unsigned SQI_INIT_LEN = 8;

  typedef logic [CTR_W-1:0]  ctr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [NIB_W-1:0]  nib_t;

  typedef enum logic [2:0] {INIT, GAP, CMD, ADDR, DUMMY, DATA} sqi_state_t;
  typedef enum logic {SQI_OP_RD, SQI_OP_WR} sqi_op_t;

  // Pending memory transaction, issued at the next GAP
  typedef struct packed {
    sqi_op_t op;
    data_t   waddr;
  } sqi_req_t;

  localparam logic [7:0] SQI_CMD_RD   = 8'h03;
  localparam logic [7:0] SQI_CMD_WR   = 8'h02;
  localparam logic [7:0] SQI_CMD_EQIO = 8'h38;

  // Memory is byte addressed; the core works in 16b words
  function automatic logic [SQI_SR_W-1:0] sqi_byte_addr(input data_t waddr);
    return {7'b0, waddr, 1'b0};
  endfunction

  // Command byte left-aligned so it leaves the shifter first
  function automatic logic [SQI_SR_W-1:0] sqi_cmd_word(input logic [7:0] cmd);
    return {cmd, 16'h0000};
  endfunction

endpackage

// File: rtl/idli_sqi_shift_m.sv
// Load/shift-out register for SQI command and address phases (and the bit-serial EQIO byte).
module idli_sqi_shift_m
  import idli_pkg::*;
#(
  parameter logic [SQI_SR_W-1:0] RST_VAL = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [SQI_SR_W-1:0] i_load_val,
  input  logic                i_shift_nib,
  input  logic                i_shift_bit,
  output nib_t                o_nib
);

  logic [SQI_SR_W-1:0] sr_q;
  logic [SQI_SR_W-1:0] sr_d;

  // Load wins over shift so the address can follow the last command nibble
  always_comb begin
    sr_d = sr_q;
    if (i_load) begin
      sr_d = i_load_val;
    end else if (i_shift_nib) begin
      sr_d = {sr_q[SQI_SR_W-NIB_W-1:0], NIB_W'(0)};
    end else if (i_shift_bit) begin
      sr_d = {sr_q[SQI_SR_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q <= RST_VAL;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign o_nib = sr_q[SQI_SR_W-1 -: NIB_W];

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// SQI memory sequencer: fetch stream, load/store redirects and the 4-GCK sync counter.
// IDLI_SQI_QUAD_INIT_EN adds an INIT phase sending EQIO bit-serially after reset.
module idli_sqi_ctrl_m
  import idli_pkg::*;
#(
  parameter data_t       RST_ADDR  = 16'h0000,
  parameter int unsigned DUMMY_CYC = 2
) (
  input  logic  i_de_gck,
  input  logic  i_de_rst_n,
  output logic  o_sq_cs_n,
  output nib_t  o_sq_sio,
  output logic  o_sq_sio_oe,
  input  nib_t  i_sq_sio,
  input  logic  i_sq_redir,
  input  logic  i_sq_redir_wr,
  input  nib_t  i_sq_addr,
  input  nib_t  i_sq_wdata,
  output ctr_t  o_de_ctr,
  output data_t o_de_enc,
  output logic  o_de_enc_vld
);

`ifdef IDLI_SQI_QUAD_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  localparam sqi_state_t          RST_STATE = INIT_EN ? INIT : GAP;
  localparam logic [SQI_SR_W-1:0] SR_RST    = INIT_EN ? sqi_cmd_word(SQI_CMD_EQIO) : '0;
  localparam sqi_req_t            RST_REQ   = '{op: SQI_OP_RD, waddr: RST_ADDR};

  sqi_state_t               state_q, state_d;
  logic [SQI_PHASE_W-1:0]   phase_q, phase_d;
  ctr_t                     ctr_q, ctr_d;
  sqi_req_t                 req_q, req_d;
  logic [DATA_W-NIB_W-1:0]  addr_q, addr_d;
  data_t                    enc_q, enc_d;
  data_t                    enc_c;

  logic                     sh_load;
  logic [SQI_SR_W-1:0]      sh_val;
  logic                     sh_nib;
  logic                     sh_bit;
  nib_t                     sh_out;
  logic                     rd_c;

  assign rd_c = (req_q.op == SQI_OP_RD);

  idli_sqi_shift_m #(.RST_VAL(SR_RST)) u_shift (
    .i_clk       (i_de_gck),
    .i_rst_n     (i_de_rst_n),
    .i_load      (sh_load),
    .i_load_val  (sh_val),
    .i_shift_nib (sh_nib),
    .i_shift_bit (sh_bit),
    .o_nib       (sh_out)
  );

  // State register
  always_ff @(posedge i_de_gck or negedge i_de_rst_n) begin
    if (!i_de_rst_n) begin
      state_q <= RST_STATE;
      phase_q <= '0;
      ctr_q   <= '0;
      req_q   <= RST_REQ;
      addr_q  <= '0;
      enc_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ctr_q   <= ctr_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      enc_q   <= enc_d;
    end
  end

  // Next state, phase/ctr counters and shifter control
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + SQI_PHASE_W'(1);
    ctr_d   = '0;
    req_d   = req_q;
    addr_d  = addr_q;
    enc_d   = enc_q;
    sh_load = 1'b0;
    sh_val  = '0;
    sh_nib  = 1'b0;
    sh_bit  = 1'b0;
    case (state_q)
      INIT: begin
        sh_bit = 1'b1;
        if (phase_q == SQI_PHASE_W'(SQI_INIT_LEN - 1)) begin
          state_d = GAP;
          phase_d = '0;
        end
      end
      GAP: begin
        sh_load = 1'b1;
        sh_val  = sqi_cmd_word(rd_c ? SQI_CMD_RD : SQI_CMD_WR);
        state_d = CMD;
        phase_d = '0;
      end
      CMD: begin
        sh_nib = 1'b1;
        if (phase_q == SQI_PHASE_W'(SQI_CMD_LEN - 1)) begin
          sh_load = 1'b1;
          sh_val  = sqi_byte_addr(req_q.waddr);
          state_d = ADDR;
          phase_d = '0;
        end
      end
      ADDR: begin
        sh_nib = 1'b1;
        if (phase_q == SQI_PHASE_W'(SQI_ADDR_LEN - 1)) begin
          state_d = (rd_c && DUMMY_CYC != 0) ? DUMMY : DATA;
          phase_d = '0;
        end
      end
      DUMMY: begin
        if (phase_q == SQI_PHASE_W'(DUMMY_CYC - 1)) begin
          state_d = DATA;
          phase_d = '0;
        end
      end
      DATA: begin
        phase_d = '0;
        ctr_d   = ctr_q + ctr_t'(1);
        addr_d  = {i_sq_addr, addr_q[DATA_W-NIB_W-1:NIB_W]};
        if (rd_c) begin
          enc_d = enc_c;
        end
        // Redirect only on a word boundary; the address nibble of this cycle is the MSB
        if (i_sq_redir && ctr_q == ctr_t'(3)) begin
          state_d   = GAP;
          req_d.op  = i_sq_redir_wr ? SQI_OP_WR : SQI_OP_RD;
          req_d.waddr = {i_sq_addr, addr_q};
        end
      end
      default: begin
        state_d = GAP;
        phase_d = '0;
      end
    endcase
  end

  // Bus outputs decode straight from state so reset releases the bus immediately
  always_comb begin
    o_sq_cs_n    = 1'b0;
    o_sq_sio     = '0;
    o_sq_sio_oe  = 1'b0;
    o_de_enc_vld = 1'b0;
    enc_c        = enc_q;
    case (state_q)
      INIT: begin
        o_sq_sio_oe = 1'b1;
        o_sq_sio    = {3'b000, sh_out[NIB_W-1]};
      end
      GAP: begin
        o_sq_cs_n = 1'b1;
      end
      CMD, ADDR: begin
        o_sq_sio_oe = 1'b1;
        o_sq_sio    = sh_out;
      end
      DUMMY: begin
        o_sq_sio_oe = 1'b0;
      end
      DATA: begin
        if (rd_c) begin
          enc_c[{ctr_q, 2'b00} +: NIB_W] = i_sq_sio;
          o_de_enc_vld = (ctr_q == ctr_t'(3));
        end else begin
          o_sq_sio_oe = 1'b1;
          o_sq_sio    = i_sq_wdata;
        end
      end
      default: begin
        o_sq_cs_n = 1'b1;
      end
    endcase
  end

  assign o_de_ctr = ctr_q;
  assign o_de_enc = enc_c;

  // Misplaced redirects are dropped; flag them so execute-side bugs are visible
  always_ff @(posedge i_de_gck) begin
    if (i_de_rst_n && i_sq_redir) begin
      assert (state_q == DATA && ctr_q == ctr_t'(3))
        else $warning("idli_sqi_ctrl_m: redirect ignored outside DATA ctr==3");
    end
  end

endmodule
